// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM states,
// default widths and the pattern-length normalisation rule.
package seq_pkg;

  localparam int DEFAULT_PAT_W = 8;
  localparam int DEFAULT_LEN_W = 4;
  localparam int DEFAULT_REP_W = 4;
  localparam int DEFAULT_GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  // A zero or oversized length request means "use the whole pattern register".
  function automatic int effective_len(input int raw_len, input int max_len);
    if (raw_len == 0 || raw_len > max_len) begin
      return max_len;
    end
    return raw_len;
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that stops at zero, with a zero flag.
// Used for the bit index, the remaining repetitions and the idle gap.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; decrementing at zero holds zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern on a valid/ready
// handshake and shifts its active window out MSB first, optionally repeating
// it with idle gaps in between, then pulses done for one cycle.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = DEFAULT_PAT_W,
  parameter int LEN_W = DEFAULT_LEN_W,
  parameter int REP_W = DEFAULT_REP_W,
  parameter int GAP_W = DEFAULT_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seqout,
  output logic             seqout_valid,
  output logic             busy,
  output logic             done
);

  state_t state;

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic [GAP_W-1:0] gap_reg;

  logic [LEN_W-1:0] len_eff_in;
  logic             handshake;
  logic             last_bit;
  logic             repeat_now;
  logic             gap_needed;

  logic             idx_load;
  logic [LEN_W-1:0] idx_load_val;
  logic             idx_dec;
  logic [LEN_W-1:0] idx_count;
  logic             idx_zero;

  logic             rep_load;
  logic             rep_dec;
  logic [REP_W-1:0] rep_count;
  logic             rep_zero;

  logic             gap_load;
  logic [GAP_W-1:0] gap_load_val;
  logic             gap_dec;
  logic [GAP_W-1:0] gap_count;
  logic             gap_zero;

  logic [PAT_W-1:0] first_vec;
  logic [PAT_W-1:0] restart_vec;
  logic [PAT_W-1:0] next_vec;

  logic             unused_counts;

  assign len_eff_in = LEN_W'(effective_len(int'(len_in), PAT_W));
  assign load_ready = (state == IDLE);
  assign handshake  = load_valid && (state == IDLE);
  assign last_bit   = (state == SHIFT) && idx_zero;
  assign repeat_now = last_bit && !rep_zero;
  assign gap_needed = (gap_reg != '0);

  // Bit selection by shifting keeps the index width independent of PAT_W.
  assign first_vec   = pat_in  >> (len_eff_in - LEN_W'(1));
  assign restart_vec = pat_reg >> (len_reg    - LEN_W'(1));
  assign next_vec    = pat_reg >> (idx_count  - LEN_W'(1));

  // The index counter always holds the position of the bit currently on seqout.
  assign idx_load     = handshake || (repeat_now && !gap_needed) ||
                        ((state == GAP) && gap_zero);
  assign idx_load_val = handshake ? (len_eff_in - LEN_W'(1)) : (len_reg - LEN_W'(1));
  assign idx_dec      = (state == SHIFT) && !idx_zero;

  assign rep_load = handshake;
  assign rep_dec  = repeat_now;

  // The gap counter is loaded with gap-1 so that zero marks the final idle cycle.
  assign gap_load     = repeat_now && gap_needed;
  assign gap_load_val = gap_reg - GAP_W'(1);
  assign gap_dec      = (state == GAP) && !gap_zero;

  // Only the zero flags of these two counters steer the FSM.
  assign unused_counts = ^{rep_count, gap_count};

  seq_down_cnt #(.W(LEN_W)) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (idx_load),
    .load_val (idx_load_val),
    .dec      (idx_dec),
    .count    (idx_count),
    .zero     (idx_zero)
  );

  seq_down_cnt #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rep_load),
    .load_val (rep_in),
    .dec      (rep_dec),
    .count    (rep_count),
    .zero     (rep_zero)
  );

  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .count    (gap_count),
    .zero     (gap_zero)
  );

  // Transfer FSM with capture registers and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pat_reg      <= '0;
      len_reg      <= '0;
      gap_reg      <= '0;
      seqout       <= 1'b0;
      seqout_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            pat_reg      <= pat_in;
            len_reg      <= len_eff_in;
            gap_reg      <= gap_in;
            seqout       <= first_vec[0];
            seqout_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= SHIFT;
          end else begin
            seqout       <= 1'b0;
            seqout_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        SHIFT: begin
          if (!idx_zero) begin
            seqout       <= next_vec[0];
            seqout_valid <= 1'b1;
          end else if (!rep_zero) begin
            if (gap_needed) begin
              seqout       <= 1'b0;
              seqout_valid <= 1'b0;
              state        <= GAP;
            end else begin
              seqout       <= restart_vec[0];
              seqout_valid <= 1'b1;
            end
          end else begin
            seqout       <= 1'b0;
            seqout_valid <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end
        end
        GAP: begin
          if (gap_zero) begin
            seqout       <= restart_vec[0];
            seqout_valid <= 1'b1;
            state        <= SHIFT;
          end else begin
            seqout       <= 1'b0;
            seqout_valid <= 1'b0;
          end
        end
        DONE: begin
          seqout       <= 1'b0;
          seqout_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a per-cycle expected-output queue
// built from the transfer rules, plus directed scenarios with literal results.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic [3:0] rep_in;
  logic [3:0] gap_in;
  logic       load_valid;
  logic       load_ready;
  logic       seqout;
  logic       seqout_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;

  // Packed view of one cycle of outputs: seqout, valid, busy, done, ready.
  typedef struct packed {
    logic s;
    logic v;
    logic b;
    logic d;
    logic r;
  } obs_t;

  localparam obs_t IDLE_E = '{s: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0, r: 1'b1};
  localparam obs_t GAP_E  = '{s: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0, r: 1'b0};
  localparam obs_t DONE_E = '{s: 1'b0, v: 1'b0, b: 1'b1, d: 1'b1, r: 1'b0};

  obs_t exp_q[$];
  obs_t cur_exp = IDLE_E;
  bit   armed   = 1'b0;

  seq_pattern_tx dut (
    .clk          (clk),
    .rst          (rst),
    .pat_in       (pat_in),
    .len_in       (len_in),
    .rep_in       (rep_in),
    .gap_in       (gap_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .seqout       (seqout),
    .seqout_valid (seqout_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Whole-transfer expected output sequence, one entry per cycle after the load edge.
  task automatic buildStream(input logic [7:0] pat, input int len, input int rep,
                             input int gap);
    int   eff;
    obs_t e;
    logic [7:0] tmp;
    eff = (len == 0 || len > 8) ? 8 : len;
    for (int r = 0; r <= rep; r++) begin
      for (int b = eff - 1; b >= 0; b--) begin
        tmp = pat >> b;
        e = '{s: tmp[0], v: 1'b1, b: 1'b1, d: 1'b0, r: 1'b0};
        exp_q.push_back(e);
      end
      if (r < rep) begin
        for (int g = 0; g < gap; g++) exp_q.push_back(GAP_E);
      end
    end
    exp_q.push_back(DONE_E);
  endtask

  // Reference model: advances the expected outputs at every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_exp = IDLE_E;
      armed   = 1'b1;
    end else if (cur_exp == IDLE_E && load_valid) begin
      buildStream(pat_in, int'(len_in), int'(rep_in), int'(gap_in));
      cur_exp = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = IDLE_E;
    end
  end

  // Compare all outputs against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("cycle_outputs",
                  {27'b0, seqout, seqout_valid, busy, done, load_ready},
                  {27'b0, cur_exp});
    end
  end

  task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] len,
                               input logic [3:0] rep, input logic [3:0] gap);
    @(negedge clk);
    pat_in     = pat;
    len_in     = len;
    rep_in     = rep;
    gap_in     = gap;
    load_valid = 1'b1;
    @(posedge clk);
  endtask

  // Sample n cycles after the load edge; bit i of each vector is cycle k+1+i.
  task automatic captureStream(input int n, input int drop_at, input int rst_at,
                               output logic [31:0] sv, output logic [31:0] vv,
                               output logic [31:0] dv, output logic [31:0] rv);
    sv = '0; vv = '0; dv = '0; rv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sv[i] = seqout;
      vv[i] = seqout_valid;
      dv[i] = done;
      rv[i] = load_ready;
      if (i == drop_at) load_valid = 1'b0;
      if (i == rst_at) rst = 1'b1;
      else if (rst_at >= 0 && i == rst_at + 1) rst = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] sv, vv, dv, rv;
    logic [2:0]  window;
    int          hits;

    rst = 1'b1; load_valid = 1'b0;
    pat_in = '0; len_in = '0; rep_in = '0; gap_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", {27'b0, seqout, seqout_valid, busy, done, load_ready},
                32'h01);
    rst = 1'b0;

    // pat 05, len 3, single shot
    applyStimulus(8'h05, 4'd3, 4'd0, 4'd0);
    captureStream(5, 0, -1, sv, vv, dv, rv);
    checkOutput("single_data", sv, 32'h05);
    checkOutput("single_valid", vv, 32'h07);
    checkOutput("single_done", dv, 32'h08);
    checkOutput("single_ready", rv, 32'h10);

    // pat 05, len 3, rep 2, gap 2
    applyStimulus(8'h05, 4'd3, 4'd2, 4'd2);
    captureStream(15, 0, -1, sv, vv, dv, rv);
    checkOutput("repgap_data", sv, 32'h14A5);
    checkOutput("repgap_valid", vv, 32'h1CE7);
    checkOutput("repgap_done", dv, 32'h2000);
    checkOutput("repgap_ready", rv, 32'h4000);

    // len 0 selects the full 8-bit pattern
    applyStimulus(8'hA5, 4'd0, 4'd0, 4'd0);
    captureStream(10, 0, -1, sv, vv, dv, rv);
    checkOutput("fulllen_data", sv, 32'h0A5);
    checkOutput("fulllen_valid", vv, 32'h0FF);
    checkOutput("fulllen_done", dv, 32'h100);

    // 101101 stream into an overlapping 101 detector
    applyStimulus(8'h05, 4'd3, 4'd1, 4'd0);
    captureStream(9, 0, -1, sv, vv, dv, rv);
    checkOutput("back2back_data", sv, 32'h02D);
    checkOutput("back2back_done", dv, 32'h040);
    hits = 0; window = '0;
    for (int i = 0; i < 9; i++) begin
      if (vv[i]) begin
        window = {window[1:0], sv[i]};
        if (window == 3'b101) hits++;
      end
    end
    checkOutput("detector_hits", 32'(hits), 32'd2);

    // load_valid held high with new values during a transfer
    applyStimulus(8'h05, 4'd3, 4'd0, 4'd0);
    #1;
    pat_in = 8'h03; len_in = 4'd2; rep_in = 4'd0; gap_in = 4'd0;
    captureStream(8, 6, -1, sv, vv, dv, rv);
    checkOutput("held_data", sv, 32'h65);
    checkOutput("held_valid", vv, 32'h67);
    checkOutput("held_done", dv, 32'h88);
    checkOutput("held_ready", rv, 32'h10);

    // reset during the second bit of an 8-bit pattern
    applyStimulus(8'hFF, 4'd8, 4'd0, 4'd0);
    captureStream(12, 0, 1, sv, vv, dv, rv);
    checkOutput("abort_data", sv, 32'h003);
    checkOutput("abort_valid", vv, 32'h003);
    checkOutput("abort_done", dv, 32'h000);
    checkOutput("abort_ready", rv, 32'hFFC);

    // Randomized traffic checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 249) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      pat_in     = 8'($urandom);
      len_in     = 4'($urandom);
      rep_in     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      gap_in     = 4'($urandom_range(0, 4));
    end
    @(negedge clk);
    rst = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
